// File: rtl/ifetch_bridge_if.sv
// ---------------------------------------------------------------------------
// ifetch_bridge_if
// Purpose : sram-like instruction bus between the fetch bridge (master) and
//           the instruction memory / cache (slave). Read-only usage.
// Signals :
//   inst_req      master->slave  request valid, held until inst_addr_ok
//   inst_wr       master->slave  write enable (always 0 for fetch)
//   inst_size     master->slave  transfer size (2'b10 = word)
//   inst_addr     master->slave  word address of the fetch
//   inst_wdata    master->slave  write data (unused, 0)
//   inst_addr_ok  slave->master  address accepted this cycle
//   inst_data_ok  slave->master  read data valid this cycle
//   inst_rdata    slave->master  read data
// ---------------------------------------------------------------------------
interface ifetch_bridge_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/ifetch_bridge.sv
// ---------------------------------------------------------------------------
// ifetch_bridge
// Purpose : converts the core's single-cycle fetch view (pcF in, instrF out,
//           inst_on as stall) into sram-like read transactions. Holds a
//           one-entry line buffer so a stalled core sees a stable instruction,
//           and drops responses belonging to fetches that were flushed.
// Ports   :
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   inst_en    in   core fetch enable
//   pcF        in   fetch PC
//   flush      in   pipeline redirect / exception
//   longstall  in   core stalled on the data side (no effect on the bridge)
//   instrF     out  instruction to the core (0 when not available)
//   inst_on    out  fetch pending, core stalls IF while 1
//   bus        sram-like master port (see ifetch_bridge_if)
// ---------------------------------------------------------------------------
module ifetch_bridge (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inst_en,
  input  logic [31:0]            pcF,
  input  logic                   flush,
  input  logic                   longstall,
  output logic [31:0]            instrF,
  output logic                   inst_on,
  ifetch_bridge_if.master        bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]  state_q,    state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        drop_q,     drop_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] buf_pc_q,   buf_pc_d;
  logic        buf_v_q,    buf_v_d;

  logic hit;
  logic fwd;
  logic misaligned;

  // The buffer simply holds its contents while the core is stalled on the
  // data side, so this input has nothing to drive.
  logic longstall_unused;
  assign longstall_unused = longstall;

  assign misaligned = (pcF[1:0] != 2'b00);
  assign hit        = buf_v_q && (buf_pc_q == pcF);
  // Forward the response in the same cycle it arrives, unless it belongs to
  // a flushed fetch or the core has already moved to another PC.
  assign fwd        = (state_q == DATA) && bus.inst_data_ok && !drop_q &&
                      (req_addr_q == pcF);

  // Read-only master: write side tied off, address comes straight from the
  // latched request so it stays stable while waiting for inst_addr_ok.
  assign bus.inst_wr    = 1'b0;
  assign bus.inst_size  = 2'b10;
  assign bus.inst_wdata = 32'h0;
  assign bus.inst_req   = (state_q == ADDR);
  assign bus.inst_addr  = req_addr_q;

  // Misaligned PCs are reported as "available" with a zero instruction so the
  // core can raise its address exception without a bus access.
  always_comb begin
    instrF = 32'h0;
    if (!rst && !misaligned) begin
      if (hit)      instrF = buf_data_q;
      else if (fwd) instrF = bus.inst_rdata;
    end
  end

  assign inst_on = !rst && inst_en && !(hit || fwd || misaligned);

  // Next-state logic. A flush never withdraws an issued request; it marks the
  // transaction to be dropped and lets it run to completion so the slave's
  // response is absorbed here rather than reaching the core.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    drop_d     = drop_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    buf_v_d    = buf_v_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          buf_v_d = 1'b0;
        end else if (inst_en && !hit && !misaligned) begin
          state_d    = ADDR;
          req_addr_d = pcF;
        end
      end
      ADDR: begin
        if (flush) begin
          drop_d  = 1'b1;
          buf_v_d = 1'b0;
        end
        if (bus.inst_addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.inst_data_ok) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (flush) begin
            buf_v_d = 1'b0;
          end else if (!drop_q) begin
            buf_data_d = bus.inst_rdata;
            buf_pc_d   = req_addr_q;
            buf_v_d    = 1'b1;
          end
        end else if (flush) begin
          drop_d  = 1'b1;
          buf_v_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset abandons any in-flight request; a late
  // inst_data_ok then arrives in IDLE and is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= 32'h0;
      drop_q     <= 1'b0;
      buf_data_q <= 32'h0;
      buf_pc_q   <= 32'h0;
      buf_v_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
      buf_data_q <= buf_data_d;
      buf_pc_q   <= buf_pc_d;
      buf_v_q    <= buf_v_d;
    end
  end

endmodule

// File: tb/tb_ifetch_bridge.sv
// ---------------------------------------------------------------------------
// tb_ifetch_bridge
// Purpose : directed self-checking bench for ifetch_bridge. Inputs change
//           1 time unit after each rising edge, outputs are checked 1 time
//           unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_ifetch_bridge;

  logic        clk;
  logic        rst;
  logic        inst_en;
  logic [31:0] pcF;
  logic        flush;
  logic        longstall;
  logic [31:0] instrF;
  logic        inst_on;

  int errorCount = 0;
  int checkCount = 0;

  ifetch_bridge_if bus ();

  ifetch_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .inst_en   (inst_en),
    .pcF       (pcF),
    .flush     (flush),
    .longstall (longstall),
    .instrF    (instrF),
    .inst_on   (inst_on),
    .bus       (bus)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and every failure
  task automatic check32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the three core/bus outputs that matter every cycle
  task automatic checkOutput(input string tag, input logic expReq,
                             input logic expOn, input logic [31:0] expInstr);
    check32({tag, ".inst_req"}, {31'h0, bus.inst_req}, {31'h0, expReq});
    check32({tag, ".inst_on"},  {31'h0, inst_on},      {31'h0, expOn});
    check32({tag, ".instrF"},   instrF,                expInstr);
  endtask

  // Drive all inputs for the current cycle, then let combinational logic settle
  task automatic applyStimulus(input logic en, input logic [31:0] pc,
                               input logic fl, input logic aok,
                               input logic dok, input logic [31:0] rdata);
    inst_en              = en;
    pcF                  = pc;
    flush                = fl;
    bus.inst_addr_ok     = aok;
    bus.inst_data_ok     = dok;
    bus.inst_rdata       = rdata;
    #1;
  endtask

  // Advance to just after the next rising edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    longstall = 1'b0;
    applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset state: nothing requested or presented even with inst_en high
    checkOutput("reset", 1'b0, 1'b0, 32'h0);
    check32("reset.inst_addr", bus.inst_addr, 32'h0);
    check32("const.inst_wr", {31'h0, bus.inst_wr}, 32'h0);
    check32("const.inst_size", {30'h0, bus.inst_size}, 32'h2);
    check32("const.inst_wdata", bus.inst_wdata, 32'h0);

    nextCycle();
    rst = 1'b0;

    // Basic miss: N miss, N+1 request+addr_ok, N+2 wait, N+3 data_ok
    applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("miss.N", 1'b0, 1'b1, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("miss.N1", 1'b1, 1'b1, 32'h0);
    check32("miss.N1.inst_addr", bus.inst_addr, 32'hBFC00000);
    nextCycle();
    applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("miss.N2", 1'b0, 1'b1, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0, 1'b1, 32'h3c010001);
    checkOutput("miss.N3", 1'b0, 1'b0, 32'h3c010001);
    nextCycle();

    // Hit while stalled on the data side: buffer holds, no new request
    longstall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("hit.stall%0d", i), 1'b0, 1'b0, 32'h3c010001);
      nextCycle();
    end
    longstall = 1'b0;

    // Flush in DATA: response for BFC00004 must be discarded
    applyStimulus(1'b1, 32'hBFC00004, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("flush.miss", 1'b0, 1'b1, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'hBFC00004, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("flush.addr", 1'b1, 1'b1, 32'h0);
    check32("flush.addr.inst_addr", bus.inst_addr, 32'hBFC00004);
    nextCycle();
    applyStimulus(1'b1, 32'hBFC00380, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("flush.data", 1'b0, 1'b1, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'hBFC00380, 1'b0, 1'b0, 1'b1, 32'hdeadbeef);
    checkOutput("flush.dropped", 1'b0, 1'b1, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'hBFC00380, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("flush.idle", 1'b0, 1'b1, 32'h0);
    nextCycle();

    // addr_ok backpressure: request and address held for 4 cycles
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hBFC00380, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("bp.wait%0d", i), 1'b1, 1'b1, 32'h0);
      check32($sformatf("bp.wait%0d.inst_addr", i), bus.inst_addr, 32'hBFC00380);
      nextCycle();
    end
    applyStimulus(1'b1, 32'hBFC00380, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("bp.accept", 1'b1, 1'b1, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'hBFC00380, 1'b0, 1'b0, 1'b1, 32'h24020005);
    checkOutput("bp.data", 1'b0, 1'b0, 32'h24020005);
    nextCycle();
    applyStimulus(1'b1, 32'hBFC00380, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("bp.hit", 1'b0, 1'b0, 32'h24020005);
    nextCycle();

    // Misaligned PC: no request ever, zero instruction, no stall
    applyStimulus(1'b1, 32'hBFC00002, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("misal.0", 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'hBFC00002, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("misal.1", 1'b0, 1'b0, 32'h0);
    nextCycle();

    // inst_en low suppresses new fetches
    applyStimulus(1'b0, 32'hBFC00010, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("noen.0", 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'hBFC00010, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("noen.1", 1'b0, 1'b0, 32'h0);

    // Async reset while in ADDR
    applyStimulus(1'b1, 32'hBFC00010, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rstaddr.miss", 1'b0, 1'b1, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'hBFC00010, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rstaddr.req", 1'b1, 1'b1, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rstaddr.async", 1'b0, 1'b0, 32'h0);
    check32("rstaddr.inst_addr", bus.inst_addr, 32'h0);
    nextCycle();
    rst = 1'b0;

    // Stale data_ok after reset lands in IDLE and is ignored
    applyStimulus(1'b0, 32'hBFC00010, 1'b0, 1'b0, 1'b1, 32'h12345678);
    checkOutput("stale.data", 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'hBFC00010, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("stale.idle", 1'b0, 1'b0, 32'h0);
    nextCycle();

    // Buffer was cleared by reset: the old PC is a miss again
    applyStimulus(1'b1, 32'hBFC00380, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("postrst.miss", 1'b0, 1'b1, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'hBFC00380, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("postrst.req", 1'b1, 1'b1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
